// File: rtl/br_jmp_resolve_unit.sv
// rtl/br_jmp_resolve_unit.sv - EX-stage branch/jump resolver with fetch redirect and direct-mapped BTB
// Resolves B/JAL/JALR one cycle after accept and updates the BTB one cycle after that.
module br_jmp_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  immediate,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             res_valid,
  output logic             res_taken,
  output logic [XLEN-1:0]  res_target,
  output logic [XLEN-1:0]  link_addr,
  output logic             misalign_err,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_addr,
  input  logic [XLEN-1:0]  btb_lookup_pc,
  output logic             btb_hit,
  output logic [XLEN-1:0]  btb_target,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic            accept, is_b, is_jal, is_jalr, is_ctrl;
  logic            cond, taken, misal, mispred;
  logic [XLEN-1:0] jalr_sum, target, seq_pc, next_pc;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [XLEN-1:0]      btb_tgt [BTB_DEPTH];

  // BTB update is deferred to the res_valid cycle; these hold what to write there.
  logic             wr_pend, clr_pend;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign in_ready = !redir_valid;
  assign accept   = in_valid && in_ready;

  always_comb begin
    is_b     = (opcode == OP_B);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    is_ctrl  = is_b || is_jal || is_jalr;
    cond     = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_val == rs2_val);
      3'b001:  cond = (rs1_val != rs2_val);
      3'b100:  cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond = (rs1_val <  rs2_val);
      3'b111:  cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
    jalr_sum = rs1_val + immediate;
    target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + immediate);
    taken    = is_jal || is_jalr || (is_b && cond);
    seq_pc   = pc + XLEN'(4);
    next_pc  = taken ? target : seq_pc;
    misal    = taken && target[1];
    mispred  = (pred_taken != taken) || (taken && (pred_target != target));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid    <= 1'b0;
      res_taken    <= 1'b0;
      res_target   <= '0;
      link_addr    <= '0;
      misalign_err <= 1'b0;
      redir_valid  <= 1'b0;
      redir_addr   <= '0;
      mispred_cnt  <= '0;
      btb_valid    <= '0;
      wr_pend      <= 1'b0;
      clr_pend     <= 1'b0;
      wr_idx       <= '0;
      wr_tag       <= '0;
    end else begin
      res_valid    <= accept && is_ctrl;
      misalign_err <= accept && is_ctrl && misal;
      wr_pend      <= accept && (is_b || is_jal) && taken && !misal;
      clr_pend     <= accept && is_b && !taken;
      if (accept && is_ctrl) begin
        res_taken  <= taken;
        res_target <= target;
        link_addr  <= seq_pc;
        wr_idx     <= pc[IDX_W+1:2];
        wr_tag     <= pc[XLEN-1:IDX_W+2];
      end
      if (accept && is_ctrl && !misal && mispred) begin
        redir_valid <= 1'b1;
        redir_addr  <= next_pc;
        if (mispred_cnt != '1)
          mispred_cnt <= mispred_cnt + CNT_W'(1);
      end else if (redir_valid && redir_ready) begin
        redir_valid <= 1'b0;
      end
      if (wr_pend)
        btb_valid[wr_idx] <= 1'b1;
      else if (clr_pend && btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag))
        btb_valid[wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pend) begin
      btb_tag[wr_idx] <= wr_tag;
      btb_tgt[wr_idx] <= res_target;
    end
  end

  // Lookup reads array state only, so a write in progress is seen from the next cycle.
  assign lk_idx     = btb_lookup_pc[IDX_W+1:2];
  assign lk_tag     = btb_lookup_pc[XLEN-1:IDX_W+2];
  assign btb_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign btb_target = btb_hit ? btb_tgt[lk_idx] : '0;

endmodule
